alu_op_sequencer: RTL and testbench

- Multi-cycle issue and control unit. It is the producer side of the ALU's operation interface.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them. Drives ALUOP and the register-read addresses, then captures the ALU's ZERO/NEG outputs into architectural flags.
- Issues register write-back or a branch decision. Sits between instruction fetch and the 8-bit ALU/register file.

---
 rtl/alu_op_seq_pkg.sv | 38 +++
 rtl/alu_op_decode.sv | 27 ++
 rtl/alu_op_sequencer.sv | 118 +++++++++++
 tb/tb_alu_op_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_op_seq_pkg.sv
// Shared constants and types for the ALU operation sequencer: opcodes, ALUOP codes,
// FSM state encoding and the decoded-instruction record.
package alu_op_seq_pkg;

  localparam logic [3:0] OPC_NOP  = 4'd0;
  localparam logic [3:0] OPC_ADD  = 4'd1;
  localparam logic [3:0] OPC_SUB  = 4'd2;
  localparam logic [3:0] OPC_NAND = 4'd3;
  localparam logic [3:0] OPC_SHL  = 4'd4;
  localparam logic [3:0] OPC_SHR  = 4'd5;
  localparam logic [3:0] OPC_BRZ  = 4'd6;
  localparam logic [3:0] OPC_BRN  = 4'd7;

  localparam logic [2:0] ALUOP_NOP  = 3'b000;
  localparam logic [2:0] ALUOP_ADD  = 3'b001;
  localparam logic [2:0] ALUOP_SUB  = 3'b010;
  localparam logic [2:0] ALUOP_NAND = 3'b011;
  localparam logic [2:0] ALUOP_SHL  = 3'b100;
  localparam logic [2:0] ALUOP_SHR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0] aluop;
    logic       is_alu;
    logic       is_branch;
    logic       br_neg;     // branch tests flag_n rather than flag_z
    logic       writes_nz;
    logic       writes_z;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: opcode -> ALU code, class bits, flag-write policy, illegal.
module alu_op_decode
  import alu_op_seq_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opc,
  output dec_t             dec
);

  always_comb begin
    dec = '0;
    case (opc)
      OPC_NOP: ;
      OPC_ADD:  begin dec.aluop = ALUOP_ADD;  dec.is_alu = 1'b1; dec.writes_nz = 1'b1; end
      OPC_SUB:  begin dec.aluop = ALUOP_SUB;  dec.is_alu = 1'b1; dec.writes_nz = 1'b1; end
      OPC_NAND: begin dec.aluop = ALUOP_NAND; dec.is_alu = 1'b1; dec.writes_nz = 1'b1; end
      // shifts report the shifted-out bit on ZERO; NEG is meaningless
      OPC_SHL:  begin dec.aluop = ALUOP_SHL;  dec.is_alu = 1'b1; dec.writes_z  = 1'b1; end
      OPC_SHR:  begin dec.aluop = ALUOP_SHR;  dec.is_alu = 1'b1; dec.writes_z  = 1'b1; end
      OPC_BRZ:  dec.is_branch = 1'b1;
      OPC_BRN:  begin dec.is_branch = 1'b1; dec.br_neg = 1'b1; end
      default:  dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Four-state issue/control unit driving the ALU operation interface and register file.
// Optional perf counters (retired_cnt, illegal_cnt) enabled by ALU_OP_SEQ_PERF_EN.
module alu_op_sequencer
  import alu_op_seq_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [2:0]        ALUOP,
  output logic [REG_AW-1:0] rd_addr1,
  output logic [REG_AW-1:0] rd_addr2,
  input  logic              ZERO,
  input  logic              NEG,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic              flag_z,
  output logic              flag_n,
  output logic              branch_taken,
  output logic [3:0]        branch_off,
  output logic              illegal_op
`ifdef ALU_OP_SEQ_PERF_EN
  ,
  output logic [15:0]       retired_cnt,
  output logic [7:0]        illegal_cnt
`endif
);

  state_e      state, state_nxt;
  logic [15:0] instr_q;
  dec_t        dec;
  logic        accept;

  assign accept = instr_valid & instr_ready;

  alu_op_decode #(.OPC_W(OPC_W)) u_dec (
    .opc (instr_q[15 -: OPC_W]),
    .dec (dec)
  );

  // read addresses come straight off the instruction latch, so they are flop outputs
  assign rd_addr1 = instr_q[4 +: REG_AW];
  assign rd_addr2 = instr_q[0 +: REG_AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = dec.illegal ? ST_IDLE : ST_EXEC;
      ST_EXEC:   state_nxt = ST_WB;
      ST_WB:     state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q      <= '0;
      instr_ready  <= 1'b1;
      ALUOP        <= ALUOP_NOP;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      flag_z       <= 1'b0;
      flag_n       <= 1'b0;
      branch_taken <= 1'b0;
      branch_off   <= '0;
      illegal_op   <= 1'b0;
    end else begin
      instr_ready  <= (state_nxt == ST_IDLE);
      // ALUOP is non-zero only during EXEC so every op produces a fresh transition
      ALUOP        <= (state_nxt == ST_EXEC) ? dec.aluop : ALUOP_NOP;
      wr_en        <= 1'b0;
      branch_taken <= 1'b0;
      illegal_op   <= 1'b0;
      if (accept) instr_q <= instr;
      if (state == ST_DECODE && dec.illegal) illegal_op <= 1'b1;
      if (state == ST_EXEC) begin
        if (dec.writes_nz) begin
          flag_z <= ZERO;
          flag_n <= NEG;
        end else if (dec.writes_z) begin
          flag_z <= ZERO;
        end
        if (dec.is_alu) begin
          wr_en   <= 1'b1;
          wr_addr <= instr_q[8 +: REG_AW];
        end
        // branches never write flags, so the current flags are the ones under test
        if (dec.is_branch) begin
          branch_taken <= dec.br_neg ? flag_n : flag_z;
          branch_off   <= instr_q[3:0];
        end
      end
    end
  end

`ifdef ALU_OP_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      illegal_cnt <= '0;
    end else begin
      if (state == ST_WB) retired_cnt <= retired_cnt + 16'd1;
      if (state == ST_DECODE && dec.illegal) illegal_cnt <= illegal_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed + random bench for alu_op_sequencer against a per-instruction reference model.
module tb_alu_op_sequencer;

  logic        clk, rst_n, instr_valid, instr_ready;
  logic [15:0] instr;
  logic [2:0]  ALUOP;
  logic [3:0]  rd_addr1, rd_addr2, wr_addr, branch_off;
  logic        ZERO, NEG, wr_en, flag_z, flag_n, branch_taken, illegal_op;
`ifdef ALU_OP_SEQ_PERF_EN
  logic [15:0] retired_cnt;
  logic [7:0]  illegal_cnt;
`endif

  int n_chk = 0, n_fail = 0;
  logic       mz = 1'b0, mn = 1'b0;
  logic [15:0] m_ret = '0;
  logic [7:0]  m_ill = '0;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .ALUOP(ALUOP), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .ZERO(ZERO), .NEG(NEG), .wr_en(wr_en), .wr_addr(wr_addr), .flag_z(flag_z),
    .flag_n(flag_n), .branch_taken(branch_taken), .branch_off(branch_off),
    .illegal_op(illegal_op)
`ifdef ALU_OP_SEQ_PERF_EN
    , .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_perf();
`ifdef ALU_OP_SEQ_PERF_EN
    chk("retired_cnt", retired_cnt, m_ret);
    chk("illegal_cnt", {8'd0, illegal_cnt}, {8'd0, m_ill});
`endif
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one instruction from an IDLE negedge and follow it back to IDLE.
  task automatic run_instr(input logic [15:0] ins, input logic z, input logic n, input bit hold);
    logic [3:0]  opc;
    logic [15:0] exp_op;
    logic        exp_wr, exp_bt;
    opc = ins[15:12];
    chk("ready_idle", instr_ready, 1);
    chk("aluop_idle", ALUOP, 0);
    instr_valid = 1'b1; instr = ins;
    ZERO = 1'($urandom); NEG = 1'($urandom);
    step(); // DECODE
    if (hold) instr = 16'($urandom); else instr_valid = 1'b0;
    chk("ready_dec", instr_ready, 0);
    chk("aluop_dec", ALUOP, 0);
    chk("rd_addr1", rd_addr1, ins[7:4]);
    chk("rd_addr2", rd_addr2, ins[3:0]);
    step();
    if (opc >= 4'd8) begin
      instr_valid = 1'b0;
      m_ill++;
      chk("illegal_pulse", illegal_op, 1);
      chk("aluop_ill", ALUOP, 0);
      chk("ready_ill", instr_ready, 1);
      chk("flag_z_ill", flag_z, mz);
      chk("flag_n_ill", flag_n, mn);
      chk_perf();
      step();
      chk("illegal_once", illegal_op, 0);
      chk("wr_en_ill", wr_en, 0);
      return;
    end
    exp_op = (opc >= 4'd1 && opc <= 4'd5) ? {12'd0, opc} : 16'd0;
    chk("aluop_exec", ALUOP, exp_op);
    chk("illegal_exec", illegal_op, 0);
    chk("rd_addr1_hold", rd_addr1, ins[7:4]);
    ZERO = z; NEG = n;
    step(); // WB
    instr_valid = 1'b0;
    ZERO = 1'($urandom); NEG = 1'($urandom);
    if (opc >= 4'd1 && opc <= 4'd3) begin mz = z; mn = n; end
    else if (opc == 4'd4 || opc == 4'd5) mz = z;
    exp_wr = (opc >= 4'd1 && opc <= 4'd5);
    exp_bt = (opc == 4'd6) ? mz : (opc == 4'd7) ? mn : 1'b0;
    chk("wr_en_wb", wr_en, exp_wr);
    if (exp_wr) chk("wr_addr", wr_addr, ins[11:8]);
    chk("branch_taken", branch_taken, exp_bt);
    if (opc == 4'd6 || opc == 4'd7) chk("branch_off", branch_off, ins[3:0]);
    chk("flag_z", flag_z, mz);
    chk("flag_n", flag_n, mn);
    chk("aluop_wb", ALUOP, 0);
    chk("ready_wb", instr_ready, 0);
    step(); // back in IDLE
    m_ret++;
    chk("wr_en_once", wr_en, 0);
    chk("branch_once", branch_taken, 0);
    chk("ready_after", instr_ready, 1);
    chk_perf();
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; ZERO = 1'b0; NEG = 1'b0;
    step(); step();
    chk("rst_ready", instr_ready, 1);
    chk("rst_aluop", ALUOP, 0);
    chk("rst_rd1", rd_addr1, 0);
    chk("rst_rd2", rd_addr2, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_pulses", {13'd0, wr_en, branch_taken, illegal_op}, 0);
    chk("rst_flags", {14'd0, flag_z, flag_n}, 0);
    chk("rst_boff", branch_off, 0);
    chk_perf();
    rst_n = 1'b1;
    step();

    // set both flags, then reset in the middle of an ADD's EXEC
    run_instr(16'h1312, 1'b1, 1'b1, 1'b0);
    instr_valid = 1'b1; instr = 16'h1567;
    step();
    instr_valid = 1'b0;
    step();
    chk("aluop_pre_rst", ALUOP, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_aluop", ALUOP, 0);
    chk("rst_mid_ready", instr_ready, 1);
    chk("rst_mid_flags", {14'd0, flag_z, flag_n}, 0);
    chk("rst_mid_wr_en", wr_en, 0);
    mz = 1'b0; mn = 1'b0; m_ret = '0; m_ill = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_hold_wr_en", wr_en, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("post_rst_pulses", {13'd0, wr_en, branch_taken, illegal_op}, 0);
    end
    chk_perf();

    // directed cases
    run_instr(16'h1312, 1'b0, 1'b0, 1'b0); // ADD rd3 rs1 1 rs2 2
    run_instr(16'h2456, 1'b1, 1'b0, 1'b1); // SUB -> flag_z=1
    run_instr(16'h3123, 1'b0, 1'b1, 1'b1); // NAND back-to-back
    run_instr(16'h3123, 1'b1, 1'b1, 1'b0);
    run_instr(16'h1000, 1'b0, 1'b1, 1'b0); // flag_n=1
    run_instr(16'h4111, 1'b1, 1'b0, 1'b0); // SHL: z=1, n held
    run_instr(16'h6004, 1'b0, 1'b1, 1'b1); // BRZ taken, off 4
    run_instr(16'h2000, 1'b0, 1'b0, 1'b0); // clear flags
    run_instr(16'h7003, 1'b1, 1'b1, 1'b0); // BRN not taken
    run_instr(16'hA123, 1'b1, 1'b1, 1'b1); // illegal
    run_instr(16'h0abc, 1'b1, 1'b1, 1'b0); // NOP

    // random traffic with random idle gaps
    for (int i = 0; i < 80; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        step();
        chk("gap_pulses", {13'd0, wr_en, branch_taken, illegal_op}, 0);
      end
      run_instr(16'($urandom), 1'($urandom), 1'($urandom), bit'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
